// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - opcodes, FSM states and command record for the ALU command sequencer
package alu_cmd_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    // Only the multiply produces a 16-bit result; everything else is the 8-bit Y.
    function automatic logic [15:0] capture_data(input logic [1:0] op,
                                                 input logic [7:0] y,
                                                 input logic [15:0] z);
        return (op == OP_MUL) ? z : {8'h00, y};
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command and result handshakes of the ALU command sequencer
interface alu_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_ovf;
    logic [1:0]  res_op;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_ovf, res_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_ovf, res_op
    );

endinterface

// File: rtl/ALU_8bit.sv
// rtl/ALU_8bit.sv - combinational 8-bit ALU (add/and/xor/mult) driven by the sequencer
module ALU_8bit
    import alu_cmd_sequencer_pkg::*;
(
    input  logic [1:0]  s,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [7:0]  Y,
    output logic [15:0] Z,
    output logic        carry,
    output logic        O
);

    logic [8:0]  sum;
    logic [15:0] prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {8'h00, A} * {8'h00, B};

    always_comb begin
        Y     = 8'h00;
        Z     = 16'h0000;
        carry = 1'b0;
        O     = 1'b0;
        case (s)
            OP_ADD: begin
                Y     = sum[7:0];
                Z     = {8'h00, sum[7:0]};
                carry = sum[8];
                // Signed overflow: like-signed operands producing an opposite-signed sum.
                O     = (A[7] == B[7]) && (sum[7] != A[7]);
            end
            OP_AND: begin
                Y = A & B;
                Z = {8'h00, A & B};
            end
            OP_XOR: begin
                Y = A ^ B;
                Z = {8'h00, A ^ B};
            end
            default: begin
                Y = prod[7:0];
                Z = prod;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with count-based full/empty, no bypass
module alu_cmd_fifo
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - ALU issue/capture stage: command FIFO, op registers, held result
// Optional: define ALU_SEQ_STICKY_OVF_EN to make res_ovf accumulate until reset.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus,
    output logic [1:0]           alu_s,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [7:0]           alu_y,
    input  logic [15:0]          alu_z,
    input  logic                 alu_carry,
    input  logic                 alu_o
);

    state_t      state;
    cmd_t        head;
    cmd_t        push_data;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        is_add;

    logic        res_valid;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_ovf;
    logic [1:0]  res_op;

    assign push_data = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    assign push      = bus.cmd_valid && !full;
    // Emptiness is the registered count, so a same-cycle push is seen next cycle.
    assign pop       = !empty && ((state == ST_IDLE) ||
                                  (state == ST_HOLD && bus.res_ready));
    assign is_add    = (alu_s == OP_ADD);

    assign bus.cmd_ready = !full;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_carry = res_carry;
    assign bus.res_ovf   = res_ovf;
    assign bus.res_op    = res_op;

    alu_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_s     <= 2'b00;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            res_op    <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        alu_s <= head.op;
                        alu_a <= head.a;
                        alu_b <= head.b;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data  <= capture_data(alu_s, alu_y, alu_z);
                    res_carry <= is_add && alu_carry;
`ifdef ALU_SEQ_STICKY_OVF_EN
                    res_ovf   <= res_ovf || (is_add && alu_o);
`else
                    res_ovf   <= is_add && alu_o;
`endif
                    res_op    <= alu_s;
                    res_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        if (!empty) begin
                            alu_s <= head.op;
                            alu_a <= head.a;
                            alu_b <= head.b;
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed vector bench for alu_cmd_sequencer with the ALU attached
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();

    logic [1:0]  alu_s;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_y;
    logic [15:0] alu_z;
    logic        alu_carry;
    logic        alu_o;

    alu_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .PTR_W      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_carry (alu_carry),
        .alu_o     (alu_o)
    );

    ALU_8bit u_alu (
        .s     (alu_s),
        .A     (alu_a),
        .B     (alu_b),
        .Y     (alu_y),
        .Z     (alu_z),
        .carry (alu_carry),
        .O     (alu_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t tbl [8];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push_try(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int max_cyc, output bit acc);
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < max_cyc && !acc; k++) begin
            if (bus.cmd_ready)
                acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit acc;
        push_try(op, a, b, 20, acc);
        check("push_accept", acc, 1);
    endtask

    task automatic wait_result(input string name, input logic [15:0] data, input logic [1:0] op,
                               output int stamp);
        bit seen = 1'b0;
        stamp = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.res_valid && bus.res_ready) begin
                seen  = 1'b1;
                stamp = cyc;
                check({name, "_data"}, bus.res_data, data);
                check({name, "_op"}, bus.res_op, op);
                check({name, "_carry"}, bus.res_carry, 0);
            end
            @(posedge clk);
            #1;
        end
        check({name, "_seen"}, seen, 1);
    endtask

    initial begin
        logic [7:0] bp_a [5];
        logic [15:0] bp_d [6];
        logic sticky;
        logic exp_ovf;
        bit acc;
        int s0, s1, s2, st;
        int extra;
        logic [15:0] held;

        tbl[0] = '{OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1};
        tbl[2] = '{OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0};
        tbl[3] = '{OP_AND, 8'hA5, 8'h0F, 16'h0005, 1'b0, 1'b0};
        tbl[4] = '{OP_XOR, 8'hA5, 8'h0F, 16'h00AA, 1'b0, 1'b0};
        tbl[5] = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
        tbl[6] = '{OP_MUL, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0};
        tbl[7] = '{OP_ADD, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b1};

        bp_a[0] = 8'h11; bp_a[1] = 8'h22; bp_a[2] = 8'h33; bp_a[3] = 8'h44; bp_a[4] = 8'h55;
        bp_d[0] = 16'h0012; bp_d[1] = 16'h0023; bp_d[2] = 16'h0034;
        bp_d[3] = 16'h0045; bp_d[4] = 16'h0056; bp_d[5] = 16'h0067;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 16'h0000);
        check("rst_flags_op", {bus.res_carry, bus.res_ovf, bus.res_op}, 4'h0);
        check("rst_alu_regs", {alu_s, alu_a, alu_b}, 18'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single commands into an idle block: latency and capture rules.
        bus.res_ready = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].op, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            check("lat_n1_valid", bus.res_valid, 0);
            check("lat_n1_alu_regs", {alu_s, alu_a, alu_b}, {tbl[i].op, tbl[i].a, tbl[i].b});
            @(posedge clk);
            #1;
            check("lat_n2_valid", bus.res_valid, 1);
            check("vec_data", bus.res_data, tbl[i].data);
            check("vec_carry", bus.res_carry, tbl[i].carry);
            check("vec_op", bus.res_op, tbl[i].op);
`ifdef ALU_SEQ_STICKY_OVF_EN
            sticky  = sticky | tbl[i].ovf;
            exp_ovf = sticky;
`else
            exp_ovf = tbl[i].ovf;
`endif
            check("vec_ovf", bus.res_ovf, exp_ovf);
            @(posedge clk);
            #1;
            check("vec_release", bus.res_valid, 0);
        end

        // Back-to-back logic/mult: order and one result every two cycles.
        fork
            begin
                push(OP_AND, 8'hA5, 8'h0F);
                push(OP_XOR, 8'hA5, 8'h0F);
                push(OP_MUL, 8'hFF, 8'hFF);
            end
            begin
                wait_result("b2b_and", 16'h0005, OP_AND, s0);
                wait_result("b2b_xor", 16'h00AA, OP_XOR, s1);
                wait_result("b2b_mul", 16'hFE01, OP_MUL, s2);
            end
        join
        check("b2b_gap1", s1 - s0, 2);
        check("b2b_gap2", s2 - s1, 2);

        // Backpressure: one held plus four queued, sixth refused.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(OP_ADD, bp_a[i], 8'h01);
        check("bp_full_ready", bus.cmd_ready, 0);
        push_try(OP_ADD, 8'h66, 8'h01, 4, acc);
        check("bp_sixth_refused", acc, 0);
        check("bp_held_valid", bus.res_valid, 1);
        held = bus.res_data;
        check("bp_held_data", held, 16'h0012);
        repeat (3) @(posedge clk);
        #1;
        check("bp_stable_data", bus.res_data, held);
        check("bp_stable_valid", bus.res_valid, 1);

        // Release the consumer while offering a command to the full FIFO.
        bus.res_ready = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_a     = 8'h66;
        bus.cmd_b     = 8'h01;
        bus.cmd_valid = 1'b1;
        check("full_pop_ready", bus.cmd_ready, 0);
        fork
            push_try(OP_ADD, 8'h66, 8'h01, 6, acc);
            begin
                for (int i = 0; i < 6; i++)
                    wait_result("drain", bp_d[i], OP_ADD, st);
            end
        join
        check("full_pop_late_accept", acc, 1);
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) extra++;
        end
        check("drain_no_duplicate", extra, 0);

        // Reset during EXEC with three commands still queued.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(OP_ADD, 8'h01, 8'h01);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_regs", {alu_s, alu_a, alu_b}, {OP_ADD, 8'h01, 8'h01});
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", bus.res_valid, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        check("midrst_res_data", bus.res_data, 16'h0000);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) extra++;
        end
        check("postrst_no_results", extra, 0);
        push(OP_ADD, 8'h02, 8'h03);
        wait_result("postrst_add", 16'h0005, OP_ADD, st);
        check("postrst_ovf", bus.res_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
